// File: rtl/conv_encode.sv
// Rate-1/2, K=3 convolutional encoder (generators 7/5 octal) that frames the
// information bits and closes each frame with two zero tail bits.
module conv_encode #(
    parameter int FRAME_LEN = 8,
    parameter int CNT_W     = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic       in_bit,
    output logic       in_ready,
    output logic [1:0] data_out,
    output logic       out_valid,
    output logic       sof,
    output logic       eof
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        TAIL = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_LEN);

    state_t           state, state_next;
    logic [1:0]       s, s_next;
    logic [CNT_W-1:0] count, count_next;
    logic             tail_idx, tail_idx_next;
    logic [1:0]       sym_next;
    logic             valid_next, sof_next, eof_next;
    logic             accept;

    // g0 = u^s1^s0 on bit 1, g1 = u^s0 on bit 0
    function automatic logic [1:0] encode(input logic u, input logic [1:0] st);
        return {u ^ st[1] ^ st[0], u ^ st[0]};
    endfunction

    assign in_ready = !rst && (state != TAIL);
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_next    = state;
        s_next        = s;
        count_next    = count;
        tail_idx_next = tail_idx;
        sym_next      = 2'b00;
        valid_next    = 1'b0;
        sof_next      = 1'b0;
        eof_next      = 1'b0;

        case (state)
            IDLE: begin
                if (accept) begin
                    sym_next   = encode(in_bit, s);
                    s_next     = {in_bit, s[1]};
                    valid_next = 1'b1;
                    sof_next   = 1'b1;
                    if (FRAME_LEN == 1) begin
                        state_next    = TAIL;
                        tail_idx_next = 1'b0;
                        count_next    = '0;
                    end else begin
                        state_next = DATA;
                        count_next = CNT_ONE;
                    end
                end
            end

            DATA: begin
                if (accept) begin
                    sym_next   = encode(in_bit, s);
                    s_next     = {in_bit, s[1]};
                    valid_next = 1'b1;
                    count_next = count + CNT_ONE;
                    if (count + CNT_ONE == CNT_LAST) begin
                        state_next    = TAIL;
                        tail_idx_next = 1'b0;
                        count_next    = '0;
                    end
                end
            end

            TAIL: begin
                sym_next   = encode(1'b0, s);
                s_next     = {1'b0, s[1]};
                valid_next = 1'b1;
                if (tail_idx) begin
                    // Shift would already give 00 here; forcing it keeps IDLE clean
                    eof_next      = 1'b1;
                    state_next    = IDLE;
                    s_next        = 2'b00;
                    count_next    = '0;
                    tail_idx_next = 1'b0;
                end else begin
                    tail_idx_next = 1'b1;
                end
            end

            default: begin
                state_next    = IDLE;
                s_next        = 2'b00;
                count_next    = '0;
                tail_idx_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            s         <= 2'b00;
            count     <= '0;
            tail_idx  <= 1'b0;
            data_out  <= 2'b00;
            out_valid <= 1'b0;
            sof       <= 1'b0;
            eof       <= 1'b0;
        end else begin
            state     <= state_next;
            s         <= s_next;
            count     <= count_next;
            tail_idx  <= tail_idx_next;
            data_out  <= sym_next;
            out_valid <= valid_next;
            sof       <= sof_next;
            eof       <= eof_next;
        end
    end

endmodule

// File: tb/tb_conv_encode.sv
// Bench for conv_encode: a frame-level reference model checked every cycle,
// plus literal symbol sequences for the known vectors.
module tb_conv_encode;

    localparam int FL = 4;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_bit;
    logic       in_ready;
    logic [1:0] data_out;
    logic       out_valid;
    logic       sof;
    logic       eof;

    int checks   = 0;
    int failures = 0;

    conv_encode #(.FRAME_LEN(FL), .CNT_W(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_bit   (in_bit),
        .in_ready (in_ready),
        .data_out (data_out),
        .out_valid(out_valid),
        .sof      (sof),
        .eof      (eof)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Reference model: the frame is a list of input bits (data then two zeros);
    // symbol k is the parity of the generator taps over bits k, k-1, k-2.
    int   frame_bits[$];
    bit   model_on = 1'b0;
    logic [1:0] e_data;
    logic e_valid, e_sof, e_eof;

    function automatic int bit_at(int k);
        return (k >= 0 && k < frame_bits.size()) ? frame_bits[k] : 0;
    endfunction

    function automatic logic [1:0] symbol_at(int k);
        int g0, g1;
        g0 = (bit_at(k) + bit_at(k - 1) + bit_at(k - 2)) % 2;
        g1 = (bit_at(k) + bit_at(k - 2)) % 2;
        return {g0[0], g1[0]};
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            model_on = 1'b1;
            frame_bits.delete();
            e_data = 2'b00; e_valid = 1'b0; e_sof = 1'b0; e_eof = 1'b0;
        end else if (model_on) begin
            e_data = 2'b00; e_valid = 1'b0; e_sof = 1'b0; e_eof = 1'b0;
            if (frame_bits.size() >= FL) begin
                frame_bits.push_back(0);
                e_data  = symbol_at(frame_bits.size() - 1);
                e_valid = 1'b1;
                e_eof   = (frame_bits.size() == FL + 2);
                if (e_eof) frame_bits.delete();
            end else if (in_valid === 1'b1) begin
                frame_bits.push_back(int'(in_bit));
                e_data  = symbol_at(frame_bits.size() - 1);
                e_valid = 1'b1;
                e_sof   = (frame_bits.size() == 1);
            end
        end
    end

    logic [3:0] obs[$];
    int         obs_cyc[$];
    int         cyc = 0;

    always @(negedge clk) begin
        if (model_on) begin
            cyc++;
            checkOutput("in_ready", 32'(in_ready), 32'(!rst && frame_bits.size() < FL));
            checkOutput("out_valid", 32'(out_valid), 32'(e_valid));
            checkOutput("data_out", 32'(data_out), 32'(e_data));
            checkOutput("sof", 32'(sof), 32'(e_sof));
            checkOutput("eof", 32'(eof), 32'(e_eof));
            if (out_valid === 1'b1) begin
                obs.push_back({sof, eof, data_out});
                obs_cyc.push_back(cyc);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic sendBit(input logic b);
        logic r;
        bit   done = 1'b0;
        in_valid = 1'b1;
        in_bit   = b;
        for (int t = 0; t < 8 && !done; t++) begin
            @(negedge clk);
            r = in_ready;
            step();
            if (r === 1'b1) done = 1'b1;
        end
        if (!done) checkOutput("handshake_timeout", 0, 1);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) step();
    endtask

    // bits[0] is sent first
    task automatic applyStimulus(input logic [15:0] bits, input int n, input bit gapped);
        for (int i = 0; i < n; i++) begin
            sendBit(bits[i]);
            if (gapped) idle(1);
        end
    endtask

    // exp holds six symbols, first symbol in the top two bits
    task automatic checkFrame(input string name, input int base, input logic [11:0] exp);
        logic [3:0] want;
        checkOutput({name, "_count"}, 32'(obs.size() >= base + 6), 1);
        if (obs.size() >= base + 6) begin
            for (int i = 0; i < 6; i++) begin
                want = {i == 0, i == 5, exp[11 - 2*i -: 2]};
                checkOutput($sformatf("%s_sym%0d", name, i), 32'(obs[base + i]), 32'(want));
            end
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [11:0] known_syms;
        logic [11:0] ones_syms;
        int          eof_seen;
        known_syms = 12'b11_10_00_01_01_11;
        ones_syms  = 12'b11_01_10_10_01_11;

        rst = 1'b1; in_valid = 1'b1; in_bit = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_in_ready", 32'(in_ready), 0);
        checkOutput("rst_out_valid", 32'(out_valid), 0);
        checkOutput("rst_data_out", 32'(data_out), 0);
        step();
        rst = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        checkOutput("release_in_ready", 32'(in_ready), 1);
        step();

        obs.delete(); obs_cyc.delete();
        applyStimulus(16'b1101, 4, 1'b0);
        idle(4);
        checkFrame("known", 0, known_syms);
        checkOutput("known_contig", 32'(obs_cyc.size() == 6 && obs_cyc[5] - obs_cyc[0] == 5), 1);

        obs.delete(); obs_cyc.delete();
        applyStimulus(16'b1111, 4, 1'b0);
        idle(4);
        checkFrame("ones", 0, ones_syms);

        obs.delete(); obs_cyc.delete();
        applyStimulus(16'b0000, 4, 1'b0);
        idle(4);
        checkFrame("zeros", 0, 12'b0);

        obs.delete(); obs_cyc.delete();
        applyStimulus(16'b1101, 4, 1'b1);
        applyStimulus(16'b0000, 4, 1'b0);
        idle(4);
        checkFrame("gap_f1", 0, known_syms);
        checkFrame("b2b_f2", 6, 12'b0);
        if (obs_cyc.size() >= 7) begin
            checkOutput("gap_spacing", 32'(obs_cyc[1] - obs_cyc[0]), 2);
            checkOutput("b2b_no_bubble", 32'(obs_cyc[6] - obs_cyc[5]), 1);
        end else begin
            checkOutput("b2b_obs_count", 32'(obs_cyc.size()), 12);
        end

        obs.delete(); obs_cyc.delete();
        applyStimulus(16'b01, 2, 1'b0);
        rst = 1'b1; in_valid = 1'b0;
        step();
        step();
        rst = 1'b0;
        idle(3);
        eof_seen = 0;
        foreach (obs[i]) if (obs[i][2]) eof_seen++;
        checkOutput("abort_symbols", 32'(obs.size()), 2);
        checkOutput("abort_no_eof", 32'(eof_seen), 0);

        obs.delete(); obs_cyc.delete();
        applyStimulus(16'b1101, 4, 1'b0);
        idle(4);
        checkFrame("after_reset", 0, known_syms);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
